// File: rtl/arm7tdmi_mem_arbiter.sv
// Fetch/data arbiter sharing one external bus port, with data lock and abort capture.
// Define ARB_TIMEOUT_EN to enable the bus-ready watchdog (TIMEOUT_CYCLES).
module arm7tdmi_mem_arbiter #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic [DATA_W-1:0] if_rdata_o,
   output logic              if_ready_o,
   output logic              if_abort_o,
   input  logic              dm_req_i,
   input  logic [ADDR_W-1:0] dm_addr_i,
   input  logic              dm_write_i,
   input  logic [1:0]        dm_size_i,
   input  logic [DATA_W-1:0] dm_wdata_i,
   input  logic [3:0]        dm_byte_en_i,
   input  logic              dm_lock_i,
   output logic [DATA_W-1:0] dm_rdata_o,
   output logic              dm_ready_o,
   output logic              dm_abort_o,
   output logic              bus_req_o,
   output logic [ADDR_W-1:0] bus_addr_o,
   output logic              bus_write_o,
   output logic [1:0]        bus_size_o,
   output logic [DATA_W-1:0] bus_wdata_o,
   output logic [3:0]        bus_byte_en_o,
   input  logic [DATA_W-1:0] bus_rdata_i,
   input  logic              bus_ready_i,
   input  logic              bus_abort_i,
   output logic              owner_o,
   output logic [ADDR_W-1:0] fault_addr_o,
   output logic              fault_src_o
);

   typedef enum logic [1:0] {IDLE, IF_XFER, DM_XFER, RESP} state_t;

   state_t            state_q;
   logic              lock_q;
   logic              owner_q;
   logic              bus_req_q;
   logic [ADDR_W-1:0] bus_addr_q;
   logic              bus_write_q;
   logic [1:0]        bus_size_q;
   logic [DATA_W-1:0] bus_wdata_q;
   logic [3:0]        bus_be_q;
   logic [DATA_W-1:0] if_rdata_q;
   logic [DATA_W-1:0] dm_rdata_q;
   logic              if_ready_q;
   logic              if_abort_q;
   logic              dm_ready_q;
   logic              dm_abort_q;
   logic [ADDR_W-1:0] fault_addr_q;
   logic              fault_src_q;

   logic grant_dm_d;
   logic done_d;
   logic abort_d;

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] tmo_q;
`endif

   always_comb begin
      // data wins when alone, when locked, or when fetch was granted last
      grant_dm_d = dm_req_i & (~if_req_i | lock_q | ~owner_q);
      done_d     = bus_ready_i | bus_abort_i;
      abort_d    = bus_abort_i;
`ifdef ARB_TIMEOUT_EN
      if (tmo_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
         done_d  = 1'b1;
         abort_d = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         lock_q       <= 1'b0;
         owner_q      <= 1'b0;
         bus_req_q    <= 1'b0;
         bus_addr_q   <= '0;
         bus_write_q  <= 1'b0;
         bus_size_q   <= 2'b00;
         bus_wdata_q  <= '0;
         bus_be_q     <= 4'h0;
         if_rdata_q   <= '0;
         dm_rdata_q   <= '0;
         if_ready_q   <= 1'b0;
         if_abort_q   <= 1'b0;
         dm_ready_q   <= 1'b0;
         dm_abort_q   <= 1'b0;
         fault_addr_q <= '0;
         fault_src_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         tmo_q        <= '0;
`endif
      end else begin
         if_ready_q <= 1'b0;
         if_abort_q <= 1'b0;
         dm_ready_q <= 1'b0;
         dm_abort_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (!dm_req_i) lock_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
               tmo_q <= '0;
`endif
               if (grant_dm_d) begin
                  state_q     <= DM_XFER;
                  owner_q     <= 1'b1;
                  bus_req_q   <= 1'b1;
                  bus_addr_q  <= dm_addr_i;
                  bus_write_q <= dm_write_i;
                  bus_size_q  <= dm_size_i;
                  bus_wdata_q <= dm_wdata_i;
                  bus_be_q    <= dm_byte_en_i;
               end else if (if_req_i) begin
                  state_q     <= IF_XFER;
                  owner_q     <= 1'b0;
                  bus_req_q   <= 1'b1;
                  bus_addr_q  <= if_addr_i;
                  bus_write_q <= 1'b0;
                  bus_size_q  <= 2'b10;
                  bus_wdata_q <= '0;
                  bus_be_q    <= 4'hF;
               end
            end
            IF_XFER, DM_XFER: begin
`ifdef ARB_TIMEOUT_EN
               tmo_q <= tmo_q + 1'b1;
`endif
               if (done_d) begin
                  state_q   <= RESP;
                  bus_req_q <= 1'b0;
                  lock_q    <= owner_q & dm_lock_i;
                  if (abort_d) begin
                     fault_addr_q <= bus_addr_q;
                     fault_src_q  <= owner_q;
                     dm_abort_q   <= owner_q;
                     if_abort_q   <= ~owner_q;
                  end else begin
                     dm_ready_q <= owner_q;
                     if_ready_q <= ~owner_q;
                     if (owner_q && !bus_write_q) dm_rdata_q <= bus_rdata_i;
                     if (!owner_q) if_rdata_q <= bus_rdata_i;
                  end
               end
            end
            RESP: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign if_rdata_o    = if_rdata_q;
   assign if_ready_o    = if_ready_q;
   assign if_abort_o    = if_abort_q;
   assign dm_rdata_o    = dm_rdata_q;
   assign dm_ready_o    = dm_ready_q;
   assign dm_abort_o    = dm_abort_q;
   assign bus_req_o     = bus_req_q;
   assign bus_addr_o    = bus_addr_q;
   assign bus_write_o   = bus_write_q;
   assign bus_size_o    = bus_size_q;
   assign bus_wdata_o   = bus_wdata_q;
   assign bus_byte_en_o = bus_be_q;
   assign owner_o       = owner_q;
   assign fault_addr_o  = fault_addr_q;
   assign fault_src_o   = fault_src_q;

endmodule

// File: tb/tb_arm7tdmi_mem_arbiter.sv
// Randomized bench for arm7tdmi_mem_arbiter with a behavioural bus-sharing model.
// Timeout checks are built only when ARB_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_arm7tdmi_mem_arbiter;
   localparam int TO = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        if_req = 0, dm_req = 0, dm_write = 0, dm_lock = 0;
   logic [31:0] if_addr = 0, dm_addr = 0, dm_wdata = 0, bus_rdata = 0;
   logic [1:0]  dm_size = 0;
   logic [3:0]  dm_be = 0;
   logic        bus_ready = 0, bus_abort = 0;
   logic [31:0] if_rdata_o, dm_rdata_o, bus_addr_o, bus_wdata_o, fault_addr_o;
   logic        if_ready_o, if_abort_o, dm_ready_o, dm_abort_o;
   logic        bus_req_o, bus_write_o, owner_o, fault_src_o;
   logic [1:0]  bus_size_o;
   logic [3:0]  bus_be_o;

   arm7tdmi_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata_o),
      .if_ready_o(if_ready_o), .if_abort_o(if_abort_o),
      .dm_req_i(dm_req), .dm_addr_i(dm_addr), .dm_write_i(dm_write),
      .dm_size_i(dm_size), .dm_wdata_i(dm_wdata), .dm_byte_en_i(dm_be),
      .dm_lock_i(dm_lock), .dm_rdata_o(dm_rdata_o),
      .dm_ready_o(dm_ready_o), .dm_abort_o(dm_abort_o),
      .bus_req_o(bus_req_o), .bus_addr_o(bus_addr_o), .bus_write_o(bus_write_o),
      .bus_size_o(bus_size_o), .bus_wdata_o(bus_wdata_o), .bus_byte_en_o(bus_be_o),
      .bus_rdata_i(bus_rdata), .bus_ready_i(bus_ready), .bus_abort_i(bus_abort),
      .owner_o(owner_o), .fault_addr_o(fault_addr_o), .fault_src_o(fault_src_o)
   );

   typedef struct packed {
      logic [31:0] addr;
      logic        write;
      logic [1:0]  size;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic        lock;
   } dtx_t;

   logic [31:0] ifq[$];
   dtx_t        dmq[$];
   bit          run_if, run_dm, gaps, noise, if_seen, dm_seen, fix_rd;
   int          if_gap, dm_gap, wait_mode, abort_mode, wcnt;
   logic [31:0] fix_rd_val;
   int          tests, fails, cyc;

   // Model: the expected value of every output, plus the lock flag
   logic        e_breq, e_bwrite, e_owner, e_fsrc, m_lock;
   logic [31:0] e_baddr, e_bwdata, e_ifrd, e_dmrd, e_faddr;
   logic [1:0]  e_bsize;
   logic [3:0]  e_bbe;
   logic        e_ifr, e_ifa, e_dmr, e_dma;
   int          m_wait;

   bit          prev_breq, prev_ifreq;
   int          grants[$];
   int          n_breq, n_ifr, n_ifa, n_dmr, n_dma;
   int          t_ifreq, t_ifrdy, t_grant, t_ifa;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         if (fails <= 40)
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic bound_fail(input string nm);
      tests++;
      fails++;
      $display("FAIL %s: cycle budget expired", nm);
   endtask

   task automatic mreset();
      {e_breq, e_bwrite, e_owner, e_fsrc, m_lock} = '0;
      {e_baddr, e_bwdata, e_ifrd, e_dmrd, e_faddr} = '0;
      e_bsize = 0; e_bbe = 0;
      {e_ifr, e_ifa, e_dmr, e_dma} = '0;
      m_wait = 0;
   endtask

   task automatic mupdate();
      bit busy_resp, to_hit;
      busy_resp = e_ifr | e_ifa | e_dmr | e_dma;
      {e_ifr, e_ifa, e_dmr, e_dma} = '0;
      to_hit = 0;
      if (busy_resp) begin
         // requester is deregistering; nothing is sampled this cycle
      end else if (e_breq) begin
`ifdef ARB_TIMEOUT_EN
         to_hit = (m_wait == TO - 1);
         m_wait++;
`endif
         if (bus_ready || bus_abort || to_hit) begin
            e_breq = 0;
            if (bus_abort || to_hit) begin
               e_faddr = e_baddr;
               e_fsrc  = e_owner;
               if (e_owner) e_dma = 1; else e_ifa = 1;
            end else if (e_owner) begin
               e_dmr = 1;
               if (!e_bwrite) e_dmrd = bus_rdata;
            end else begin
               e_ifr  = 1;
               e_ifrd = bus_rdata;
            end
            m_lock = e_owner && dm_lock;
         end
      end else begin
         if (!dm_req) m_lock = 0;
         if (dm_req && (!if_req || m_lock || !e_owner)) begin
            e_owner = 1; e_breq = 1; m_wait = 0;
            e_baddr = dm_addr; e_bwrite = dm_write; e_bsize = dm_size;
            e_bwdata = dm_wdata; e_bbe = dm_be;
         end else if (if_req) begin
            e_owner = 0; e_breq = 1; m_wait = 0;
            e_baddr = if_addr; e_bwrite = 0; e_bsize = 2'b10;
            e_bwdata = 0; e_bbe = 4'hF;
         end
      end
   endtask

   task automatic compare();
      chk("bus_req", bus_req_o, e_breq);
      chk("bus_addr", bus_addr_o, e_baddr);
      chk("bus_write", bus_write_o, e_bwrite);
      chk("bus_size", bus_size_o, e_bsize);
      chk("bus_wdata", bus_wdata_o, e_bwdata);
      chk("bus_be", bus_be_o, e_bbe);
      chk("owner", owner_o, e_owner);
      chk("if_rdata", if_rdata_o, e_ifrd);
      chk("dm_rdata", dm_rdata_o, e_dmrd);
      chk("if_ready", if_ready_o, e_ifr);
      chk("if_abort", if_abort_o, e_ifa);
      chk("dm_ready", dm_ready_o, e_dmr);
      chk("dm_abort", dm_abort_o, e_dma);
      chk("fault_addr", fault_addr_o, e_faddr);
      chk("fault_src", fault_src_o, e_fsrc);
   endtask

   task automatic monitor();
      if (bus_req_o) n_breq++;
      if (bus_req_o && !prev_breq) begin
         grants.push_back(int'(owner_o));
         t_grant = cyc;
      end
      prev_breq = bus_req_o;
      if (if_req && !prev_ifreq) t_ifreq = cyc;
      prev_ifreq = if_req;
      if (if_ready_o) begin n_ifr++; t_ifrdy = cyc; end
      if (if_abort_o) begin n_ifa++; t_ifa = cyc; end
      if (dm_ready_o) n_dmr++;
      if (dm_abort_o) n_dma++;
      if (if_ready_o || if_abort_o) if_seen = 1;
      if (dm_ready_o || dm_abort_o) dm_seen = 1;
   endtask

   task automatic drive();
      dtx_t t;
      if (if_seen) begin
         if (ifq.size() > 0) ifq.delete(0);
         if_seen = 0;
         if_gap = gaps ? $urandom_range(0, 2) : 0;
      end
      if (if_gap > 0) begin
         if_gap--; if_req = 0;
      end else begin
         if_req = run_if && ifq.size() > 0;
         if (if_req) if_addr = ifq[0];
      end
      if (dm_seen) begin
         if (dmq.size() > 0) dmq.delete(0);
         dm_seen = 0;
         dm_gap = gaps ? $urandom_range(0, 2) : 0;
      end
      if (dm_gap > 0) begin
         dm_gap--; dm_req = 0;
      end else begin
         dm_req = run_dm && dmq.size() > 0;
         if (dm_req) begin
            t = dmq[0];
            dm_addr = t.addr; dm_write = t.write; dm_size = t.size;
            dm_wdata = t.wdata; dm_be = t.be; dm_lock = t.lock;
         end
      end
      if (bus_req_o) begin
         if (wcnt == 0) begin
            bus_ready = 1;
            bus_abort = (abort_mode == 2) ||
                        (abort_mode == 1 && $urandom_range(0, 4) == 0);
         end else begin
            bus_ready = 0; bus_abort = 0;
            if (wcnt > 0) wcnt--;
         end
      end else begin
         wcnt = (wait_mode == -1) ? $urandom_range(0, 3) :
                (wait_mode == -2) ? -1 : wait_mode;
         bus_ready = noise && $urandom_range(0, 2) == 0;
         bus_abort = noise && $urandom_range(0, 4) == 0;
      end
      bus_rdata = fix_rd ? fix_rd_val : $urandom;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      drive();
      @(negedge clk);
      cyc++;
      if (rst) mreset();
      compare();
      monitor();
      if (!rst) mupdate();
   endtask

   task automatic clr_mon();
      grants.delete();
      {n_breq, n_ifr, n_ifa, n_dmr, n_dma} = '0;
   endtask

   task automatic quiesce();
      ifq.delete(); dmq.delete();
      {run_if, run_dm, gaps, noise, if_seen, dm_seen} = '0;
      if_gap = 0; dm_gap = 0;
      if_req = 0; dm_req = 0;
   endtask

   task automatic do_reset();
      quiesce();
      rst = 1;
      repeat (2) step();
      rst = 0;
      step();
      clr_mon();
   endtask

   task automatic run_until_empty(input string nm, input int budget);
      int n;
      n = 0;
      while ((ifq.size() > 0 || dmq.size() > 0) && n < budget) begin
         step(); n++;
      end
      if (n >= budget) bound_fail(nm);
      repeat (3) step();
   endtask

   function automatic dtx_t mk(input logic [31:0] a, input logic w,
                               input logic [1:0] s, input logic [31:0] d,
                               input logic [3:0] be, input logic lk);
      dtx_t t;
      t.addr = a; t.write = w; t.size = s; t.wdata = d; t.be = be; t.lock = lk;
      return t;
   endfunction

   initial begin
      tests = 0; fails = 0; cyc = 0;
      wait_mode = 0; abort_mode = 0; fix_rd = 0; fix_rd_val = 0; wcnt = 0;
      prev_breq = 0; prev_ifreq = 0;
      mreset();
      do_reset();
      chk("rst_bus_req", bus_req_o, 0);
      chk("rst_owner", owner_o, 0);
      chk("rst_fault_addr", fault_addr_o, 0);
      chk("rst_if_rdata", if_rdata_o, 0);

      // fetch only, zero-wait bus
      fix_rd = 1; fix_rd_val = 32'hE3A01001;
      ifq.push_back(32'h100);
      run_if = 1;
      run_until_empty("fetch_only", 30);
      chk("fetch_breq_cycles", n_breq, 1);
      chk("fetch_ready_pulses", n_ifr, 1);
      chk("fetch_rdata", if_rdata_o, 32'hE3A01001);
      chk("fetch_turnaround", t_ifrdy - t_ifreq, 2);
      fix_rd = 0;

      // simultaneous requests from reset alternate, data first (owner=0)
      do_reset();
      for (int i = 0; i < 4; i++) begin
         ifq.push_back(32'h200 + 4 * i);
         dmq.push_back(mk(32'h1000, 0, 2'b10, 0, 4'hF, 0));
      end
      run_if = 1; run_dm = 1;
      run_until_empty("simultaneous", 100);
      chk("alt_grant_count", grants.size(), 8);
      for (int i = 0; i < 8 && i < grants.size(); i++)
         chk($sformatf("alt_grant%0d", i), grants[i], (i % 2 == 0) ? 1 : 0);
      chk("alt_if_ready", n_ifr, 4);
      chk("alt_dm_ready", n_dmr, 4);

      // lock keeps data ownership against a waiting fetch
      quiesce(); clr_mon();
      for (int i = 0; i < 4; i++)
         dmq.push_back(mk(32'h3000 + 4 * i, 0, 2'b10, 0, 4'hF, i < 3));
      ifq.push_back(32'h400);
      run_dm = 1;
      step();
      run_if = 1;
      run_until_empty("lock", 100);
      chk("lock_grant_count", grants.size(), 5);
      for (int i = 0; i < 5 && i < grants.size(); i++)
         chk($sformatf("lock_grant%0d", i), grants[i], (i < 4) ? 1 : 0);

      // store pass-through with three wait states
      quiesce(); clr_mon();
      wait_mode = 3;
      dmq.push_back(mk(32'h2004, 1, 2'b01, 32'hCAFE, 4'b0011, 0));
      run_dm = 1;
      for (int n = 0; n < 20 && n_dmr == 0; n++) begin
         step();
         if (bus_req_o) begin
            chk("st_addr", bus_addr_o, 32'h2004);
            chk("st_write", bus_write_o, 1);
            chk("st_size", bus_size_o, 2'b01);
            chk("st_wdata", bus_wdata_o, 32'hCAFE);
            chk("st_be", bus_be_o, 4'b0011);
         end
      end
      repeat (3) step();
      chk("st_breq_cycles", n_breq, 4);
      chk("st_ready_pulses", n_dmr, 1);

      // abort wins over ready
      quiesce(); clr_mon();
      wait_mode = 0; abort_mode = 2;
      dmq.push_back(mk(32'h1001, 0, 2'b10, 0, 4'hF, 0));
      run_dm = 1;
      run_until_empty("abort", 30);
      chk("ab_abort_pulses", n_dma, 1);
      chk("ab_ready_pulses", n_dmr, 0);
      chk("ab_fault_addr", fault_addr_o, 32'h1001);
      chk("ab_fault_src", fault_src_o, 1);
      abort_mode = 0;

`ifdef ARB_TIMEOUT_EN
      quiesce(); clr_mon();
      wait_mode = -2;
      ifq.push_back(32'h500);
      run_if = 1;
      run_until_empty("timeout", TO + 30);
      chk("to_abort_pulses", n_ifa, 1);
      chk("to_latency", t_ifa - t_grant, TO);
      chk("to_fault_addr", fault_addr_o, 32'h500);
      chk("to_fault_src", fault_src_o, 0);
      wait_mode = 0;
`endif

      // reset in the middle of a data transfer
      quiesce(); clr_mon();
      wait_mode = -2;
      dmq.push_back(mk(32'h6000, 0, 2'b10, 0, 4'hF, 0));
      run_dm = 1;
      for (int n = 0; n < 10 && !bus_req_o; n++) step();
      step();
      chk("pre_rst_bus_req", bus_req_o, 1);
      rst = 1;
      #1;
      chk("rst_kills_bus_req", bus_req_o, 0);
      quiesce(); clr_mon();
      repeat (2) step();
      rst = 0;
      wait_mode = 0;
      repeat (6) step();
      chk("rst_no_pulses", n_dmr + n_dma + n_ifr + n_ifa, 0);
      chk("rst_idle_breq", n_breq, 0);

      // randomized traffic
      quiesce(); clr_mon();
      wait_mode = -1; abort_mode = 1;
      for (int i = 0; i < 150; i++) begin
         ifq.push_back({$urandom_range(0, 32'hFFFF), 2'b00});
         dmq.push_back(mk($urandom, 1'($urandom_range(0, 1)),
                          2'($urandom_range(0, 2)), $urandom,
                          4'($urandom_range(0, 15)),
                          $urandom_range(0, 2) == 0));
      end
      run_if = 1; run_dm = 1; gaps = 1; noise = 1;
      run_until_empty("random", 8000);
      chk("rand_if_done", n_ifr + n_ifa, 150);
      chk("rand_dm_done", n_dmr + n_dma, 150);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
